// File: rtl/audio_filter_dac.sv
// Audio back end: sample-rate divider, one-pole low-pass, volume/mute stage and a
// first-order sigma-delta modulator producing a 1-bit DAC stream.
module audio_filter_dac #(
  parameter int CLK_DIV  = 256,
  parameter int LP_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sin,
  input  logic [1:0]  vol,
  input  logic        mute,
  output logic [15:0] pcm,
  output logic        pcm_valid,
  output logic        dac_out
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  logic [15:0]        cnt_q, cnt_d;
  logic               tick;
  logic               stage1_q, stage2_q;
  logic               pcm_valid_q;
  logic signed [15:0] x_q, x_d;
  logic signed [15:0] lp_q, lp_d;
  logic signed [15:0] pcm_q, pcm_d;
  logic signed [16:0] diff, step;
  logic [16:0]        acc_q, acc_d;

  // NOTE: every signal gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    // (sin - 128) << 7: flipping the MSB turns offset-binary into two's complement.
    x_d = tick ? {~sin[7], ~sin[7], sin[6:0], 7'd0} : x_q;

    // 17-bit difference keeps x - lp exact; the floor shift keeps lp inside x range.
    diff = {x_q[15], x_q} - {lp_q[15], lp_q};
    step = diff >>> LP_SHIFT;
    lp_d = stage1_q ? 16'({lp_q[15], lp_q} + step) : lp_q;

    pcm_d = pcm_q;
    if (stage2_q) begin
      if (mute || (vol == 2'd3)) pcm_d = 16'sd0;
      else                       pcm_d = lp_q >>> vol;
    end

    acc_d = {1'b0, acc_q[15:0]} + {1'b0, pcm_q ^ 16'h8000};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      stage1_q    <= 1'b0;
      stage2_q    <= 1'b0;
      pcm_valid_q <= 1'b0;
      x_q         <= '0;
      lp_q        <= '0;
      pcm_q       <= '0;
      acc_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stage1_q    <= tick;
      stage2_q    <= stage1_q;
      pcm_valid_q <= stage2_q;
      x_q         <= x_d;
      lp_q        <= lp_d;
      pcm_q       <= pcm_d;
      acc_q       <= acc_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign dac_out   = acc_q[16];

endmodule

// File: tb/tb_audio_filter_dac.sv
// Bench for audio_filter_dac: a filtered instance (CLK_DIV=4, LP_SHIFT=2) and a bypass
// instance (CLK_DIV=5, LP_SHIFT=0) driven in parallel against a sample-period model.
module tb_audio_filter_dac;

  logic        clk;
  logic        reset;
  logic [7:0]  sin;
  logic [1:0]  vol;
  logic        mute;
  logic [15:0] pcm_w   [2];
  logic        valid_w [2];
  logic        dac_w   [2];

  int vectors    = 0;
  int miscompares = 0;

  audio_filter_dac #(.CLK_DIV(4), .LP_SHIFT(2)) u_dut (
    .clk(clk), .reset(reset), .sin(sin), .vol(vol), .mute(mute),
    .pcm(pcm_w[0]), .pcm_valid(valid_w[0]), .dac_out(dac_w[0])
  );

  audio_filter_dac #(.CLK_DIV(5), .LP_SHIFT(0)) u_byp (
    .clk(clk), .reset(reset), .sin(sin), .vol(vol), .mute(mute),
    .pcm(pcm_w[1]), .pcm_valid(valid_w[1]), .dac_out(dac_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int sh_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int floor_div_pow2(int v, int s);
    int d;
    d = 1 << s;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  // Reference model: cycle c counts from the first cycle after reset release; the
  // sample period starts at the tick cycle c = DIV-1 and repeats every DIV cycles.
  int m_c   [2];
  int m_x   [2];
  int m_lp  [2];
  int m_pcm [2];
  int m_acc [2];
  bit m_valid [2];
  bit m_dac   [2];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_c[k] <= 0; m_x[k] <= 0; m_lp[k] <= 0; m_pcm[k] <= 0; m_acc[k] <= 0;
        m_valid[k] <= 1'b0; m_dac[k] <= 1'b0;
      end else begin
        m_acc[k]   <= (m_acc[k] % 65536) + m_pcm[k] + 32768;
        m_dac[k]   <= (((m_acc[k] % 65536) + m_pcm[k] + 32768) >= 65536);
        m_valid[k] <= 1'b0;
        m_c[k]     <= m_c[k] + 1;
        if (m_c[k] >= div_of(k) - 1) begin
          case ((m_c[k] - div_of(k) + 1) % div_of(k))
            0: m_x[k] <= (int'(sin) - 128) * 128;
            1: m_lp[k] <= m_lp[k] + floor_div_pow2(m_x[k] - m_lp[k], sh_of(k));
            2: begin
              m_pcm[k]   <= (mute || vol == 2'd3) ? 0 : floor_div_pow2(m_lp[k], int'(vol));
              m_valid[k] <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int first [2];
    int nval  [2];
    int exp_n;
    reset = 1'b1; sin = 8'd255; vol = 2'd0; mute = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pcm_w[k] !== 16'd0 || valid_w[k] !== 1'b0 || dac_w[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: pcm=%0d valid=%b dac=%b, expected pcm=0 valid=0 dac=0",
                 k, $signed(pcm_w[k]), valid_w[k], dac_w[k]);
      end
    end
    reset = 1'b0;
    first = '{-1, -1};
    nval  = '{0, 0};
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (valid_w[k] === 1'b1) begin
          nval[k]++;
          if (first[k] < 0) first[k] = c;
        end
    end
    for (int k = 0; k < 2; k++) begin
      exp_n = 0;
      for (int c = 1; c <= 30; c++)
        if (c >= div_of(k) + 2 && (c - div_of(k) - 2) % div_of(k) == 0) exp_n++;
      vectors++;
      if (first[k] !== div_of(k) + 2) begin
        miscompares++;
        $display("FAIL first_valid dut%0d: cycle=%0d, expected %0d", k, first[k], div_of(k) + 2);
      end
      vectors++;
      if (nval[k] !== exp_n) begin
        miscompares++;
        $display("FAIL valid_count dut%0d: got %0d strobes, expected %0d", k, nval[k], exp_n);
      end
    end
  endtask

  task automatic test_silence();
    logic prev [2];
    sin = 8'd128; vol = 2'd0; mute = 1'b0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (pcm_w[k] !== 16'd0 || valid_w[k] !== m_valid[k]) begin
          miscompares++;
          $display("FAIL silence dut%0d c=%0d: pcm=%0d valid=%b, expected pcm=0 valid=%b",
                   k, c, $signed(pcm_w[k]), valid_w[k], m_valid[k]);
        end
        if (c >= 2) begin
          vectors++;
          if (dac_w[k] === prev[k]) begin
            miscompares++;
            $display("FAIL dac_alternate dut%0d c=%0d: dac=%b, expected %b", k, c, dac_w[k], ~prev[k]);
          end
        end
        prev[k] = dac_w[k];
      end
    end
  endtask

  task automatic test_step();
    int smp [2][40];
    int ns  [2];
    sin = 8'd255; vol = 2'd0; mute = 1'b0;
    do_reset();
    ns = '{0, 0};
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (valid_w[k] === 1'b1 && ns[k] < 40) begin
          smp[k][ns[k]] = int'($signed(pcm_w[k]));
          ns[k]++;
        end
    end
    vectors++;
    if (ns[0] < 35 || ns[1] < 30) begin
      miscompares++;
      $display("FAIL step_samples: got %0d/%0d samples, expected at least 35/30", ns[0], ns[1]);
    end else begin
      vectors++;
      if (smp[0][0] != 4064 || smp[0][1] != 7112 || smp[0][2] != 9398) begin
        miscompares++;
        $display("FAIL step_first3: got %0d %0d %0d, expected 4064 7112 9398",
                 smp[0][0], smp[0][1], smp[0][2]);
      end
      for (int i = 1; i < ns[0]; i++) begin
        vectors++;
        if (smp[0][i] < smp[0][i-1]) begin
          miscompares++;
          $display("FAIL step_monotonic i=%0d: got %0d after %0d, expected non-decreasing",
                   i, smp[0][i], smp[0][i-1]);
        end
      end
      vectors++;
      if (smp[0][ns[0]-1] < 16253 || smp[0][ns[0]-1] > 16256) begin
        miscompares++;
        $display("FAIL step_settle: got %0d, expected 16253..16256", smp[0][ns[0]-1]);
      end
      for (int i = 0; i < ns[1]; i++) begin
        vectors++;
        if (smp[1][i] != 16256) begin
          miscompares++;
          $display("FAIL bypass_step i=%0d: got %0d, expected 16256", i, smp[1][i]);
        end
      end
    end
  endtask

  function automatic int exp_first(int k, int v);
    int base;
    base = (k == 0) ? -4096 : -16384;
    return (v == 3) ? 0 : base / (1 << v);
  endfunction

  task automatic test_vol();
    logic [15:0] got  [2];
    bit          seen [2];
    for (int v = 0; v < 4; v++) begin
      sin = 8'd0; vol = 2'(v); mute = 1'b0;
      do_reset();
      seen = '{1'b0, 1'b0};
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++)
          if (valid_w[k] === 1'b1 && !seen[k]) begin
            got[k]  = pcm_w[k];
            seen[k] = 1'b1;
          end
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (!seen[k] || got[k] !== 16'(exp_first(k, v))) begin
          miscompares++;
          $display("FAIL vol%0d dut%0d: seen=%0b pcm=%0d, expected %0d",
                   v, k, seen[k], $signed(got[k]), exp_first(k, v));
        end
      end
    end
  endtask

  task automatic test_mute();
    int  exp_pre;
    bit  found;
    sin = 8'd255; vol = 2'd0; mute = 1'b0;
    do_reset();
    repeat (250) @(negedge clk);
    exp_pre = m_pcm[0];
    vectors++;
    if (pcm_w[0] !== 16'(exp_pre) || exp_pre < 16253) begin
      miscompares++;
      $display("FAIL mute_steady: pcm=%0d, expected %0d (16253..16256)", $signed(pcm_w[0]), exp_pre);
    end
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      found = (valid_w[0] === 1'b1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mute_sync: no pcm_valid within 8 cycles, expected one every 4");
    end
    mute = 1'b1;
    repeat (4) @(negedge clk);
    mute = 1'b0;
    vectors++;
    if (valid_w[0] !== 1'b1 || pcm_w[0] !== 16'd0) begin
      miscompares++;
      $display("FAIL mute_sample: valid=%b pcm=%0d, expected valid=1 pcm=0", valid_w[0], $signed(pcm_w[0]));
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (valid_w[0] !== 1'b1 || pcm_w[0] !== 16'(exp_pre)) begin
      miscompares++;
      $display("FAIL mute_recover: valid=%b pcm=%0d, expected valid=1 pcm=%0d",
               valid_w[0], $signed(pcm_w[0]), exp_pre);
    end
  endtask

  task automatic test_reset_mid();
    bit          found;
    int          first [2];
    logic [15:0] got   [2];
    sin = 8'd255; vol = 2'd0; mute = 1'b0;
    do_reset();
    repeat (20) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      found = (valid_w[0] === 1'b1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pcm_w[k] !== 16'd0 || valid_w[k] !== 1'b0 || dac_w[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_async dut%0d: pcm=%0d valid=%b dac=%b, expected all 0",
                 k, $signed(pcm_w[k]), valid_w[k], dac_w[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    first = '{-1, -1};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (first[k] < 0 && valid_w[k] === 1'b1) begin
          first[k] = c;
          got[k]   = pcm_w[k];
        end else if (first[k] < 0) begin
          vectors++;
          if (pcm_w[k] !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_flush dut%0d c=%0d: pcm=%0d, expected 0", k, c, $signed(pcm_w[k]));
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (first[k] !== div_of(k) + 2 || got[k] !== ((k == 0) ? 16'd4064 : 16'd16256)) begin
        miscompares++;
        $display("FAIL reset_restart dut%0d: first=%0d pcm=%0d, expected first=%0d pcm=%0d",
                 k, first[k], $signed(got[k]), div_of(k) + 2, (k == 0) ? 4064 : 16256);
      end
    end
  endtask

  task automatic test_density();
    int ones [2];
    sin = 8'd0; vol = 2'd0; mute = 1'b0;
    do_reset();
    repeat (200) @(negedge clk);
    ones = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pcm_w[k] !== 16'hC000) begin
        miscompares++;
        $display("FAIL density_pcm dut%0d: pcm=%0d, expected -16384", k, $signed(pcm_w[k]));
      end
    end
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (dac_w[k] === 1'b1) ones[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ones[k] < 63 || ones[k] > 65) begin
        miscompares++;
        $display("FAIL density dut%0d: %0d ones in 256 cycles, expected 64 +/- 1", k, ones[k]);
      end
    end
  endtask

  task automatic test_random();
    sin = 8'($urandom); vol = 2'($urandom); mute = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (valid_w[k] !== m_valid[k] || pcm_w[k] !== 16'(m_pcm[k]) || dac_w[k] !== m_dac[k]) begin
          miscompares++;
          $display("FAIL random dut%0d i=%0d: valid=%b pcm=%0d dac=%b, expected valid=%b pcm=%0d dac=%b",
                   k, i, valid_w[k], $signed(pcm_w[k]), dac_w[k], m_valid[k], m_pcm[k], m_dac[k]);
        end
      end
      sin = 8'($urandom);
      if ($urandom_range(7) == 0)  vol  = 2'($urandom);
      if ($urandom_range(15) == 0) mute = ~mute;
      reset = ($urandom_range(199) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sin = 8'd128; vol = 2'd0; mute = 1'b0;
    test_reset();
    test_silence();
    test_step();
    test_vol();
    test_mute();
    test_reset_mid();
    test_density();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_filter_dac.md
AUDIO_FILTER_DAC -- requirements
Module: audio_filter_dac

Interface
REQ-001 Parameter CLK_DIV, default 256: number of clk cycles per audio sample period; legal range 4..65535.
REQ-002 Parameter LP_SHIFT, default 2: low-pass filter coefficient exponent; legal range 0..4; 0 = filter bypass.
REQ-003 Port clk, input, 1: single system clock; all logic synchronous to its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sin, input, 8: unsigned mixed sound sample from the sound-output stage; 128 = silence.
REQ-006 Port vol, input, 2: attenuation select.
REQ-007 Port mute, input, 1: forces silent output.
REQ-008 Port pcm, output, 16: signed two's-complement filtered sample.
REQ-009 Port pcm_valid, output, 1: one-cycle strobe marking a new pcm value.
REQ-010 Port dac_out, output, 1: first-order sigma-delta bitstream of pcm.

Function
REQ-011 Divider counter SHALL count 0..CLK_DIV-1 and wrap to 0; internal tick SHALL be high in the cycle where counter = CLK_DIV-1.
REQ-012 Stage 1: on the edge ending a tick cycle T, x SHALL load (sin - 128) << 7, signed 16-bit, range -16384..16256.
REQ-013 Stage 2: on the next edge (end of T+1), lp SHALL load lp + ((x - lp) >>> LP_SHIFT), computed at 17 bits with arithmetic (floor) shift; if LP_SHIFT = 0, lp SHALL load x.
REQ-014 lp SHALL always stay within x range, so no saturation is required; with floor shift, a positive step settles up to 2^LP_SHIFT-1 LSB below target.
REQ-015 Stage 3: on the edge ending T+2, pcm SHALL load lp >>> vol for vol = 0..2, and 0 for vol = 3 or mute = 1.
REQ-016 pcm_valid SHALL be high in exactly cycle T+3, one cycle per sample period, and low otherwise.
REQ-017 sin, vol and mute SHALL be sampled only at the stage that uses them (REQ-012, REQ-015); changes between those stages take effect in the next sample period.
REQ-018 The sigma-delta accumulator SHALL run every cycle: acc[16:0] <= acc[15:0] + (pcm XOR 16'h8000); dac_out SHALL be the registered carry acc[16].
REQ-019 Long-run dac_out density SHALL equal (pcm + 32768) / 65536; pcm = 0 gives exactly alternating 1/0 after settling.
REQ-020 The pipeline SHALL be free-running with no backpressure; the consumer must accept pcm in its pcm_valid cycle.

Reset
REQ-021 While reset is high: counter, x, lp, pcm, acc SHALL be 0 and pcm_valid, dac_out SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-pipeline SHALL discard in-flight samples; after deassertion, the first tick SHALL occur at cycle CLK_DIV-1 and the first pcm_valid at cycle CLK_DIV+2.

Verification
REQ-023 CLK_DIV=4, LP_SHIFT=2, sin=128, vol=0 -> pcm_valid every 4 cycles, pcm=0, dac_out alternates 1/0.
REQ-024 sin steps 128->255, vol=0 -> successive pcm 4064, 7112, 9398, ... monotonic, settling at 16256 or up to 3 LSB below.
REQ-025 sin=0, first sample after reset, vol=0/1/2/3 -> pcm -4096/-2048/-1024/0.
REQ-026 Steady pcm=16256, mute asserted for one sample -> that sample pcm=0; the next sample returns to 16256 because lp is unaffected by mute.
REQ-027 Reset pulse asserted between stage 1 and stage 3 -> all outputs 0 immediately; no pcm_valid until cycle CLK_DIV+2 after release.
REQ-028 Constant pcm=-16384 -> dac_out density is 16384/65536 = 25% over 256 cycles, within ±1 count.
